// File: rtl/button_event_ctrl_pkg.sv
// Shared types and helpers for the button event controller and its bench.
package btn_evt_pkg;

    typedef enum logic [1:0] {
        EVT_CLICK  = 2'd0,
        EVT_LONG   = 2'd1,
        EVT_REPEAT = 2'd2
    } evt_kind_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_t;

    // Width of a button index; a single button still needs one bit.
    function automatic int btn_w(input int n_btn);
        return (n_btn > 1) ? $clog2(n_btn) : 1;
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/button_event_ctrl_if.sv
// Event stream from the button controller to the stopwatch control FSM.
interface button_event_ctrl_if
    import btn_evt_pkg::*;
#(
    parameter int N_BTN = 3
);
    localparam int BTN_W = btn_w(N_BTN);

    logic             evt_valid;
    logic             evt_ready;
    logic [BTN_W-1:0] evt_btn;
    evt_kind_t        evt_kind;
    logic             overflow;

    modport master (
        output evt_valid,
        output evt_btn,
        output evt_kind,
        output overflow,
        input  evt_ready
    );

    modport slave (
        input  evt_valid,
        input  evt_btn,
        input  evt_kind,
        input  overflow,
        output evt_ready
    );

endinterface

// File: rtl/button_event_ctrl_ms_tick_gen.sv
// Free-running millisecond prescaler: one-cycle tick at the terminal count.
module ms_tick_gen #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);
    localparam int DIV = (CLK_FREQ / 1000 > 1) ? CLK_FREQ / 1000 : 1;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_q;

    assign tick = (cnt_q == CW'(DIV - 1));

    // Count 0..DIV-1 and wrap on the tick cycle.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Turns debounced button levels into CLICK/LONG/REPEAT events and
// round-robin arbitrates them onto one valid/ready stream.
module button_event_ctrl
    import btn_evt_pkg::*;
#(
    parameter int N_BTN     = 3,
    parameter int CLK_FREQ  = 50_000_000,
    parameter int LONG_MS   = 1000,
    parameter int REPEAT_MS = 200
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [N_BTN-1:0]    btn_db,
    button_event_ctrl_if.master evt_if
);
    localparam int BTN_W   = btn_w(N_BTN);
    localparam int CNT_MAX = max_int(LONG_MS, REPEAT_MS);
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    logic             tick;
    logic [N_BTN-1:0] prev_btn_q;
    logic [N_BTN-1:0] rise;
    logic [N_BTN-1:0] pend;
    logic [N_BTN-1:0] drop;
    logic [N_BTN-1:0] grant;
    evt_kind_t        pend_kind [N_BTN];

    logic             evt_valid_q, evt_valid_d;
    logic [BTN_W-1:0] evt_btn_q, evt_btn_d;
    evt_kind_t        evt_kind_q, evt_kind_d;
    logic             overflow_q;
    logic [BTN_W-1:0] last_grant_q, last_grant_d;
    logic [BTN_W-1:0] win_idx;
    logic [BTN_W-1:0] cand;
    logic             found;

    ms_tick_gen #(.CLK_FREQ(CLK_FREQ)) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    // Previous levels reset high so a button held through reset needs a fresh press.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev_btn_q <= '1;
        end else begin
            prev_btn_q <= btn_db;
        end
    end

    assign rise = btn_db & ~prev_btn_q;

    for (genvar i = 0; i < N_BTN; i++) begin : g_btn
        btn_state_t       state_q, state_d;
        logic [CNT_W-1:0] cnt_q, cnt_d;
        logic             emit_q, emit_d;
        evt_kind_t        emit_kind_q, emit_kind_d;
        logic             pend_q, pend_d;
        evt_kind_t        kind_q, kind_d;
        logic             drop_c;

        // Press classifier: release beats a same-cycle tick.
        // NOTE: every combinational output gets a default first so no latch is inferred.
        always_comb begin
            state_d     = state_q;
            cnt_d       = cnt_q;
            emit_d      = 1'b0;
            emit_kind_d = EVT_CLICK;
            case (state_q)
                IDLE: begin
                    if (rise[i]) begin
                        state_d = PRESSED;
                        cnt_d   = '0;
                    end
                end
                PRESSED: begin
                    if (!btn_db[i]) begin
                        emit_d      = 1'b1;
                        emit_kind_d = EVT_CLICK;
                        state_d     = IDLE;
                    end else if (tick) begin
                        if (cnt_q == CNT_W'(LONG_MS - 1)) begin
                            emit_d      = 1'b1;
                            emit_kind_d = EVT_LONG;
                            state_d     = HELD;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                HELD: begin
                    if (!btn_db[i]) begin
                        state_d = IDLE;
                    end else if (tick) begin
                        if (cnt_q == CNT_W'(REPEAT_MS - 1)) begin
                            emit_d      = 1'b1;
                            emit_kind_d = EVT_REPEAT;
                            cnt_d       = '0;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        // Pending slot: keep the older event if the slot is busy and not being drained.
        always_comb begin
            pend_d = pend_q;
            kind_d = kind_q;
            drop_c = 1'b0;
            if (emit_q) begin
                if (pend_q && !grant[i]) begin
                    drop_c = 1'b1;
                end else begin
                    pend_d = 1'b1;
                    kind_d = emit_kind_q;
                end
            end else if (grant[i]) begin
                pend_d = 1'b0;
            end
        end

        // Per-button state, hold counter, registered emit and pending slot.
        always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                emit_q      <= 1'b0;
                emit_kind_q <= EVT_CLICK;
                pend_q      <= 1'b0;
                kind_q      <= EVT_CLICK;
            end else begin
                state_q     <= state_d;
                cnt_q       <= cnt_d;
                emit_q      <= emit_d;
                emit_kind_q <= emit_kind_d;
                pend_q      <= pend_d;
                kind_q      <= kind_d;
            end
        end

        assign pend[i]      = pend_q;
        assign pend_kind[i] = kind_q;
        assign drop[i]      = drop_c;
    end

    // Round-robin pick starting after the last granted button, only when the output can load.
    always_comb begin
        found   = 1'b0;
        win_idx = last_grant_q;
        cand    = '0;
        grant   = '0;
        if (!evt_valid_q || evt_if.evt_ready) begin
            for (int k = 1; k <= N_BTN; k++) begin
                cand = BTN_W'((int'(last_grant_q) + k) % N_BTN);
                if (!found && pend[cand]) begin
                    found   = 1'b1;
                    win_idx = cand;
                end
            end
        end
        if (found) begin
            grant[win_idx] = 1'b1;
        end
    end

    // Output register: hold while stalled, drop valid after a transfer with nothing pending.
    always_comb begin
        evt_valid_d  = evt_valid_q & ~evt_if.evt_ready;
        evt_btn_d    = evt_btn_q;
        evt_kind_d   = evt_kind_q;
        last_grant_d = last_grant_q;
        if (found) begin
            evt_valid_d  = 1'b1;
            evt_btn_d    = win_idx;
            evt_kind_d   = pend_kind[win_idx];
            last_grant_d = win_idx;
        end
    end

    // Output stage, arbiter pointer and the merged overflow pulse.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            evt_valid_q  <= 1'b0;
            evt_btn_q    <= '0;
            evt_kind_q   <= EVT_CLICK;
            last_grant_q <= '0;
            overflow_q   <= 1'b0;
        end else begin
            evt_valid_q  <= evt_valid_d;
            evt_btn_q    <= evt_btn_d;
            evt_kind_q   <= evt_kind_d;
            last_grant_q <= last_grant_d;
            overflow_q   <= |drop;
        end
    end

    assign evt_if.evt_valid = evt_valid_q;
    assign evt_if.evt_btn   = evt_btn_q;
    assign evt_if.evt_kind  = evt_kind_q;
    assign evt_if.overflow  = overflow_q;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Scenario bench for button_event_ctrl with a scoreboard on the event stream.
module tb_button_event_ctrl;
    import btn_evt_pkg::*;

    localparam int N_BTN     = 3;
    localparam int CLK_FREQ  = 10_000;
    localparam int LONG_MS   = 5;
    localparam int REPEAT_MS = 2;

    typedef struct packed {
        logic [1:0] btn;
        logic [1:0] kind;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n = 1'b0;
    logic [N_BTN-1:0] btn_db = '0;

    exp_t exp_q[$];
    exp_t mon_e;
    int   checks     = 0;
    int   failures   = 0;
    int   transfers  = 0;
    int   ovf_pulses = 0;

    button_event_ctrl_if #(.N_BTN(N_BTN)) evt_if ();

    button_event_ctrl #(
        .N_BTN     (N_BTN),
        .CLK_FREQ  (CLK_FREQ),
        .LONG_MS   (LONG_MS),
        .REPEAT_MS (REPEAT_MS)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .btn_db  (btn_db),
        .evt_if  (evt_if)
    );

    always #5 clk = ~clk;

    // Scoreboard: every accepted event must match the oldest expected one.
    always @(negedge clk) begin
        if (reset_n && evt_if.overflow) ovf_pulses++;
        if (reset_n && evt_if.evt_valid && evt_if.evt_ready) begin
            transfers++;
            checks++;
            if (exp_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_event: got btn=%0d kind=%0d, expected none",
                         evt_if.evt_btn, evt_if.evt_kind);
            end else begin
                mon_e = exp_q.pop_front();
                if (evt_if.evt_btn !== mon_e.btn || evt_if.evt_kind !== mon_e.kind) begin
                    failures++;
                    $display("FAIL event_match: got btn=%0d kind=%0d, expected btn=%0d kind=%0d",
                             evt_if.evt_btn, evt_if.evt_kind, mon_e.btn, mon_e.kind);
                end
            end
        end
    end

    // Advance n rising edges, leaving time just past the last edge for driving inputs.
    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_event(input int btn, input evt_kind_t kind);
        exp_t e;
        e.btn  = 2'(btn);
        e.kind = kind;
        exp_q.push_back(e);
    endtask

    task automatic check_drained(input string name, input int base, input int n_exp);
        checks++;
        if (exp_q.size() !== 0 || transfers - base !== n_exp) begin
            failures++;
            $display("FAIL %s: got %0d transfers with %0d still expected, expected %0d transfers with 0 left",
                     name, transfers - base, exp_q.size(), n_exp);
        end
    endtask

    task automatic test_reset;
        evt_if.evt_ready = 1'b1;
        reset_n = 1'b0;
        cycles(3);
        @(negedge clk);
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            failures++; $display("FAIL reset_valid: got %b expected 0", evt_if.evt_valid);
        end
        checks++;
        if (evt_if.evt_btn !== 2'd0) begin
            failures++; $display("FAIL reset_btn: got %0d expected 0", evt_if.evt_btn);
        end
        checks++;
        if (evt_if.evt_kind !== EVT_CLICK) begin
            failures++; $display("FAIL reset_kind: got %0d expected 0", evt_if.evt_kind);
        end
        checks++;
        if (evt_if.overflow !== 1'b0) begin
            failures++; $display("FAIL reset_overflow: got %b expected 0", evt_if.overflow);
        end
        @(posedge clk); #1;
        reset_n = 1'b1;
        cycles(5);
    endtask

    // Single click on btn0 with exact output latency.
    task automatic test_click;
        int base;
        base = transfers;
        btn_db[0] = 1'b1;
        cycles(20);
        expect_event(0, EVT_CLICK);
        btn_db[0] = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            failures++; $display("FAIL click_latency_early: got valid=%b expected 0 one edge after pend", evt_if.evt_valid);
        end
        @(negedge clk);
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_btn !== 2'd0) begin
            failures++;
            $display("FAIL click_latency: got valid=%b btn=%0d expected valid=1 btn=0",
                     evt_if.evt_valid, evt_if.evt_btn);
        end
        cycles(10);
        check_drained("click_drain", base, 1);
    endtask

    // btn0 and btn2 released together after last grant went to btn0.
    task automatic test_simultaneous;
        int base;
        base = transfers;
        btn_db = 3'b101;
        cycles(20);
        expect_event(2, EVT_CLICK);
        expect_event(0, EVT_CLICK);
        btn_db = 3'b000;
        repeat (4) @(negedge clk);
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_btn !== 2'd2) begin
            failures++;
            $display("FAIL rr_first: got valid=%b btn=%0d expected valid=1 btn=2", evt_if.evt_valid, evt_if.evt_btn);
        end
        @(negedge clk);
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_btn !== 2'd0) begin
            failures++;
            $display("FAIL rr_second: got valid=%b btn=%0d expected valid=1 btn=0", evt_if.evt_valid, evt_if.evt_btn);
        end
        cycles(10);
        check_drained("rr_drain", base, 2);
    endtask

    // Long hold on btn1: LONG, three REPEATs, nothing on release.
    task automatic test_long_repeat;
        int base;
        base = transfers;
        expect_event(1, EVT_LONG);
        repeat (3) expect_event(1, EVT_REPEAT);
        btn_db[1] = 1'b1;
        cycles(115);
        btn_db[1] = 1'b0;
        cycles(30);
        check_drained("long_repeat_drain", base, 4);
    endtask

    // btn2 held through reset must stay silent until pressed again.
    task automatic test_reset_held;
        int base;
        reset_n = 1'b0;
        btn_db[2] = 1'b1;
        cycles(3);
        reset_n = 1'b1;
        base = transfers;
        cycles(30);
        btn_db[2] = 1'b0;
        cycles(20);
        check_drained("held_through_reset", base, 0);
        base = transfers;
        expect_event(2, EVT_CLICK);
        btn_db[2] = 1'b1;
        cycles(5);
        btn_db[2] = 1'b0;
        cycles(10);
        check_drained("click_after_reset", base, 1);
    endtask

    // Wait one cycle while stalled and confirm the held btn0 CLICK does not move.
    task automatic stall_cycle(inout int bad);
        @(negedge clk);
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_btn !== 2'd0 || evt_if.evt_kind !== EVT_CLICK) bad++;
        @(posedge clk); #1;
    endtask

    // Three clicks into a stalled stream: one held, one pending, one dropped.
    task automatic test_overflow;
        int base, ovf_base, bad;
        base = transfers;
        ovf_base = ovf_pulses;
        bad = 0;
        evt_if.evt_ready = 1'b0;
        expect_event(0, EVT_CLICK);
        expect_event(0, EVT_CLICK);
        btn_db[0] = 1'b1;
        cycles(3);
        btn_db[0] = 1'b0;
        cycles(4);
        for (int c = 0; c < 2; c++) begin
            btn_db[0] = 1'b1;
            repeat (3) stall_cycle(bad);
            btn_db[0] = 1'b0;
            repeat (6) stall_cycle(bad);
        end
        checks++;
        if (bad !== 0) begin
            failures++; $display("FAIL stall_stable: got %0d unstable cycles expected 0", bad);
        end
        checks++;
        if (ovf_pulses - ovf_base !== 1) begin
            failures++; $display("FAIL overflow_pulses: got %0d expected 1", ovf_pulses - ovf_base);
        end
        evt_if.evt_ready = 1'b1;
        cycles(10);
        check_drained("overflow_drain", base, 2);
    endtask

    // Reset while btn1 is HELD and its LONG is stalled at the output.
    task automatic test_reset_mid;
        int base;
        evt_if.evt_ready = 1'b0;
        btn_db[1] = 1'b1;
        cycles(60);
        checks++;
        if (evt_if.evt_valid !== 1'b1 || evt_if.evt_btn !== 2'd1 || evt_if.evt_kind !== EVT_LONG) begin
            failures++;
            $display("FAIL mid_pending: got valid=%b btn=%0d kind=%0d expected valid=1 btn=1 kind=1",
                     evt_if.evt_valid, evt_if.evt_btn, evt_if.evt_kind);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if (evt_if.evt_valid !== 1'b0) begin
            failures++; $display("FAIL mid_reset_valid: got %b expected 0", evt_if.evt_valid);
        end
        base = transfers;
        evt_if.evt_ready = 1'b1;
        cycles(3);
        reset_n = 1'b1;
        cycles(10);
        btn_db[1] = 1'b0;
        cycles(40);
        check_drained("mid_reset_silent", base, 0);
    endtask

    initial begin
        evt_if.evt_ready = 1'b1;
        test_reset();
        test_click();
        test_simultaneous();
        test_long_repeat();
        test_reset_held();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
